// File: rtl/prog_loader.sv
// prog_loader: byte-stream program loader writing words into instruction memory.
// Receives a 16-bit word count (low byte first) and count*BPW payload bytes over
// a valid/ready byte channel, assembles little-endian words and issues one-cycle
// write strobes to imem while holding the CPU stalled.
// Optional feature macro: LOADER_CSUM_EN (trailing XOR checksum byte, CHK state).
// Ports:
//   clock, reset              clock (rising edge), async active-low reset
//   load                      start request, sampled only in IDLE
//   in_data/in_valid/in_ready byte channel, transfer = in_valid && in_ready
//   mem_we/mem_addr/mem_wdata imem write port, mem_we qualifies addr/data
//   cpu_hold                  CPU stall request for the duration of a load
//   done                      one-cycle end-of-load pulse
//   err                       sticky error, cleared when the next load starts
module prog_loader #(
  parameter int unsigned nInstr = 7,
  parameter int unsigned ilen   = 32
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              load,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  output logic              mem_we,
  output logic [nInstr-1:0] mem_addr,
  output logic [ilen-1:0]   mem_wdata,
  output logic              cpu_hold,
  output logic              done,
  output logic              err
);

  localparam int unsigned BPW   = ilen / 8;
  localparam int unsigned BCW   = (BPW > 1) ? $clog2(BPW) : 1;
  localparam int unsigned IW    = nInstr + 1;
  localparam int unsigned DEPTH = 2 ** nInstr;

`ifdef LOADER_CSUM_EN
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, WRITE, CHK, DONE} state_e;
  localparam state_e FIN = CHK;
`else
  typedef enum logic [2:0] {IDLE, CNT_LO, CNT_HI, DATA, WRITE, DONE} state_e;
  localparam state_e FIN = DONE;
`endif

  state_e              state_q, state_d;
  logic [IW-1:0]       idx_q, idx_d;
  logic [15:0]         cnt_q, cnt_d;
  logic [ilen-1:0]     word_q, word_d;
  logic [BCW-1:0]      byte_q, byte_d;
  logic                in_ready_q, in_ready_d;
  logic                mem_we_q, mem_we_d;
  logic [nInstr-1:0]   mem_addr_q, mem_addr_d;
  logic [ilen-1:0]     mem_wdata_q, mem_wdata_d;
  logic                cpu_hold_q, cpu_hold_d;
  logic                done_q, done_d;
  logic                err_q, err_d;
`ifdef LOADER_CSUM_EN
  logic [7:0]          csum_q, csum_d;
`endif

  logic xfer;
  assign xfer = in_valid && in_ready_q;

  // State and output registers.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      idx_q       <= '0;
      cnt_q       <= '0;
      word_q      <= '0;
      byte_q      <= '0;
      in_ready_q  <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      cpu_hold_q  <= 1'b0;
      done_q      <= 1'b0;
      err_q       <= 1'b0;
`ifdef LOADER_CSUM_EN
      csum_q      <= '0;
`endif
    end else begin
      state_q     <= state_d;
      idx_q       <= idx_d;
      cnt_q       <= cnt_d;
      word_q      <= word_d;
      byte_q      <= byte_d;
      in_ready_q  <= in_ready_d;
      mem_we_q    <= mem_we_d;
      mem_addr_q  <= mem_addr_d;
      mem_wdata_q <= mem_wdata_d;
      cpu_hold_q  <= cpu_hold_d;
      done_q      <= done_d;
      err_q       <= err_d;
`ifdef LOADER_CSUM_EN
      csum_q      <= csum_d;
`endif
    end
  end

  // Next-state logic; outputs are derived from the next state so they register
  // in the same cycle the FSM enters the corresponding state.
  always_comb begin
    state_d     = state_q;
    idx_d       = idx_q;
    cnt_d       = cnt_q;
    word_d      = word_q;
    byte_d      = byte_q;
    err_d       = err_q;
    mem_we_d    = 1'b0;
    mem_addr_d  = mem_addr_q;
    mem_wdata_d = mem_wdata_q;
`ifdef LOADER_CSUM_EN
    csum_d      = csum_q;
`endif
    case (state_q)
      IDLE: begin
        if (load) begin
          state_d = CNT_LO;
          err_d   = 1'b0;
          idx_d   = '0;
          byte_d  = '0;
`ifdef LOADER_CSUM_EN
          csum_d  = '0;
`endif
        end
      end
      CNT_LO: begin
        if (xfer) begin
          cnt_d   = {cnt_q[15:8], in_data};
          state_d = CNT_HI;
        end
      end
      CNT_HI: begin
        if (xfer) begin
          cnt_d = {in_data, cnt_q[7:0]};
          if (cnt_d == 16'd0) begin
            state_d = FIN;
          end else if (32'(cnt_d) > 32'(DEPTH)) begin
            // Oversized program: reject without consuming payload or checksum.
            err_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = DATA;
          end
        end
      end
      DATA: begin
        if (xfer) begin
          word_d[{byte_q, 3'b000} +: 8] = in_data;
`ifdef LOADER_CSUM_EN
          csum_d = csum_q ^ in_data;
`endif
          if (byte_q == BCW'(BPW - 1)) begin
            byte_d      = '0;
            state_d     = WRITE;
            mem_we_d    = 1'b1;
            mem_addr_d  = idx_q[nInstr-1:0];
            mem_wdata_d = word_d;
          end else begin
            byte_d = byte_q + BCW'(1);
          end
        end
      end
      WRITE: begin
        idx_d   = idx_q + IW'(1);
        state_d = (16'(idx_d) == cnt_q) ? FIN : DATA;
      end
`ifdef LOADER_CSUM_EN
      CHK: begin
        if (xfer) begin
          if (in_data != csum_q) err_d = 1'b1;
          state_d = DONE;
        end
      end
`endif
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    in_ready_d = (state_d == CNT_LO) || (state_d == CNT_HI) || (state_d == DATA)
`ifdef LOADER_CSUM_EN
                 || (state_d == CHK)
`endif
                 ;
    cpu_hold_d = (state_d != IDLE);
    done_d     = (state_d == DONE);
  end

  assign in_ready  = in_ready_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_hold  = cpu_hold_q;
  assign done      = done_q;
  assign err       = err_q;

endmodule

// File: tb/tb_prog_loader.sv
// tb_prog_loader: directed self-checking bench for prog_loader with a write
// scoreboard. Expected imem writes are queued as payload is driven and popped
// when mem_we is observed. Checksum steps are included when LOADER_CSUM_EN is set.
module tb_prog_loader;

  localparam int unsigned NI = 7;
  localparam int unsigned IL = 32;

  logic          clock = 1'b0;
  logic          reset = 1'b0;
  logic          load = 1'b0;
  logic [7:0]    in_data = 8'h00;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic          mem_we;
  logic [NI-1:0] mem_addr;
  logic [IL-1:0] mem_wdata;
  logic          cpu_hold;
  logic          done;
  logic          err;

  prog_loader #(.nInstr(NI), .ilen(IL)) dut (
    .clock(clock), .reset(reset), .load(load),
    .in_data(in_data), .in_valid(in_valid), .in_ready(in_ready),
    .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .cpu_hold(cpu_hold), .done(done), .err(err)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [NI-1:0] a;
    logic [IL-1:0] d;
  } wr_t;

  wr_t           sb[$];
  int            errors = 0;
  int            checks = 0;
  int            we_cnt = 0;
  logic [NI-1:0] exp_addr = '0;
  logic [7:0]    exp_csum = 8'h00;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, got, exp);
    end
  endtask

  // Scoreboard consumer: every write must match the oldest queued expectation.
  wr_t mon_e;
  always @(negedge clock) begin
    if (reset && mem_we) begin
      we_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL unexpected_write observed addr=%0d data=%h expected none", mem_addr, mem_wdata);
      end
      if (sb.size() != 0) begin
        mon_e = sb.pop_front();
        chk("wr_addr", 32'(mem_addr), 32'(mon_e.a));
        chk("wr_data", mem_wdata, mon_e.d);
      end
      chk("rdy_in_write", 32'(in_ready), 32'd0);
    end
  end

  task automatic start_load;
    load = 1'b1;
    @(negedge clock);
    load = 1'b0;
    chk("hold_after_load", 32'(cpu_hold), 32'd1);
    chk("rdy_cnt_lo", 32'(in_ready), 32'd1);
    chk("err_cleared", 32'(err), 32'd0);
    exp_addr = '0;
    exp_csum = 8'h00;
  endtask

  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t;
    t = 0;
    in_data  = b;
    in_valid = 1'b1;
    while (!in_ready && t < 100) begin
      @(negedge clock);
      t++;
    end
    checks++;
    assert (t < 100) else begin
      errors++;
      $error("FAIL byte_timeout observed in_ready=0 expected 1");
    end
    @(negedge clock);
    if (gap) begin
      in_valid = 1'b0;
      @(negedge clock);
    end
  endtask

  task automatic send_count(input int n, input bit gap);
    send_byte(n[7:0], gap);
    send_byte(n[15:8], gap);
  endtask

  task automatic send_word(input logic [31:0] w, input bit gap, input bit pulse_load);
    logic [7:0] b;
    sb.push_back('{exp_addr, w});
    exp_addr = exp_addr + 1'b1;
    for (int i = 0; i < 4; i++) begin
      b = w[8*i +: 8];
      exp_csum = exp_csum ^ b;
      send_byte(b, gap);
      if (pulse_load && i == 1) begin
        in_valid = 1'b0;
        load = 1'b1;
        @(negedge clock);
        load = 1'b0;
        chk("hold_load_ignored", 32'(cpu_hold), 32'd1);
      end
    end
  endtask

  task automatic wait_done(input logic exp_err);
    int t;
    t = 0;
    in_valid = 1'b0;
    while (!done && t < 200) begin
      @(negedge clock);
      t++;
    end
    chk("done_seen", 32'(done), 32'd1);
    chk("hold_in_done", 32'(cpu_hold), 32'd1);
    chk("err_at_done", 32'(err), 32'(exp_err));
    @(negedge clock);
    chk("done_one_cycle", 32'(done), 32'd0);
    chk("hold_released", 32'(cpu_hold), 32'd0);
    chk("rdy_idle", 32'(in_ready), 32'd0);
    chk("err_sticky", 32'(err), 32'(exp_err));
  endtask

  task automatic finish_load(input logic exp_err);
`ifdef LOADER_CSUM_EN
    send_byte(exp_csum, 1'b0);
`endif
    wait_done(exp_err);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_rdy"},   32'(in_ready), 32'd0);
    chk({tag, "_we"},    32'(mem_we), 32'd0);
    chk({tag, "_addr"},  32'(mem_addr), 32'd0);
    chk({tag, "_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_hold"},  32'(cpu_hold), 32'd0);
    chk({tag, "_done"},  32'(done), 32'd0);
    chk({tag, "_err"},   32'(err), 32'd0);
  endtask

  initial begin
    int we0;
    logic [31:0] w;

    // Reset state.
    repeat (3) @(negedge clock);
    chk_reset_outputs("rst");
    reset = 1'b1;
    @(negedge clock);
    chk("hold_idle", 32'(cpu_hold), 32'd0);

    // Single word.
    we0 = we_cnt;
    start_load();
    send_count(1, 1'b0);
    send_word(32'h12345678, 1'b0, 1'b0);
    finish_load(1'b0);
    chk("single_we_count", 32'(we_cnt - we0), 32'd1);
    chk("addr_holds", 32'(mem_addr), 32'd0);
    chk("wdata_holds", mem_wdata, 32'h12345678);

    // Two words with in_valid gaps.
    start_load();
    send_count(2, 1'b1);
    send_word(32'hDEADBEEF, 1'b1, 1'b0);
    send_word(32'h00000013, 1'b1, 1'b0);
    finish_load(1'b0);

    // Count overflow: 129 words > depth 128.
    we0 = we_cnt;
    start_load();
    send_count(129, 1'b0);
    wait_done(1'b1);
    chk("ovf_no_write", 32'(we_cnt - we0), 32'd0);
    repeat (3) @(negedge clock);
    chk("ovf_rdy_after", 32'(in_ready), 32'd0);

    // Full memory: 128 words, err cleared by the accepted load.
    start_load();
    send_count(128, 1'b0);
    for (int i = 0; i < 128; i++) begin
      w = $urandom;
      send_word(w, 1'b0, 1'b0);
    end
    finish_load(1'b0);
    chk("full_last_addr", 32'(mem_addr), 32'd127);

    // Zero count.
    we0 = we_cnt;
    start_load();
    send_count(0, 1'b0);
    finish_load(1'b0);
    chk("zero_no_write", 32'(we_cnt - we0), 32'd0);

    // load pulsed during DATA is ignored; index continues.
    start_load();
    send_count(2, 1'b0);
    send_word(32'hA5A55A5A, 1'b0, 1'b0);
    send_word(32'h0BADF00D, 1'b0, 1'b1);
    finish_load(1'b0);

    // Reset mid-word: partial word discarded, outputs return to reset values.
    we0 = we_cnt;
    start_load();
    send_count(1, 1'b0);
    send_byte(8'h11, 1'b0);
    send_byte(8'h22, 1'b0);
    in_valid = 1'b0;
    reset = 1'b0;
    #1;
    chk_reset_outputs("midrst");
    @(negedge clock);
    reset = 1'b1;
    @(negedge clock);
    chk("midrst_no_write", 32'(we_cnt - we0), 32'd0);
    start_load();
    send_count(1, 1'b0);
    send_word(32'hCAFEF00D, 1'b0, 1'b0);
    finish_load(1'b0);

`ifdef LOADER_CSUM_EN
    // Good checksum: 01^02^03^04 = 04.
    start_load();
    send_count(1, 1'b0);
    send_word(32'h04030201, 1'b0, 1'b0);
    send_byte(8'h04, 1'b0);
    wait_done(1'b0);

    // Bad checksum: word still written, err set and sticky.
    we0 = we_cnt;
    start_load();
    send_count(1, 1'b0);
    send_word(32'h04030201, 1'b0, 1'b0);
    send_byte(8'h05, 1'b0);
    wait_done(1'b1);
    chk("csum_word_written", 32'(we_cnt - we0), 32'd1);
    start_load();
    send_count(0, 1'b0);
    finish_load(1'b0);
`endif

    repeat (2) @(negedge clock);
    chk("sb_empty", 32'(sb.size()), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
